// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input, reload pulse, imem write port and status of the boot loader.
// slave is the loader side; master is the board/environment side.
interface program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load_request;
    logic [31:0] imem_write_address;
    logic [31:0] imem_write_value;
    logic        imem_write_enable;
    logic        processor_reset;
    logic        loader_done;
    logic        loader_error;
    logic [15:0] words_loaded;
    modport slave (
        input  byte_valid, byte_data, load_request,
        output byte_ready, imem_write_address, imem_write_value, imem_write_enable,
        output processor_reset, loader_done, loader_error, words_loaded
    );
    modport master (
        output byte_valid, byte_data, load_request,
        input  byte_ready, imem_write_address, imem_write_value, imem_write_enable,
        input  processor_reset, loader_done, loader_error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles a big-endian byte stream into imem words, then releases the processor.
// Defining LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked before release.
module program_loader #(
    parameter int MEM_WORDS = 256
) (
    input logic            clock_i,
    input logic            reset_i,
    program_loader_if.slave bus
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {COUNT_HI, COUNT_LO, DATA, CHECK, FLUSH, RUN, ERROR} state_e;
    localparam state_e AFTER_DATA = CHECK;
`else
    typedef enum logic [2:0] {COUNT_HI, COUNT_LO, DATA, FLUSH, RUN, ERROR} state_e;
    localparam state_e AFTER_DATA = FLUSH;
`endif
    state_e      state_q, state_d;
    logic [15:0] count_q, count_d, idx_q, idx_d, words_q, words_d;
    logic [23:0] word_q, word_d;
    logic [31:0] addr_q, addr_d, val_q, val_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        we_q, we_d, flush_q, flush_d;
    logic        xfer, load, word_end;
    logic [15:0] n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign load     = bus.load_request && (state_q == RUN || state_q == ERROR);
    assign n        = {count_q[15:8], bus.byte_data};
    assign word_end = xfer && state_q == DATA && bcnt_q == 2'd3;
    always_ff @(posedge clock_i) state_q <= reset_i ? COUNT_HI : state_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            COUNT_HI: state_d = xfer ? COUNT_LO : COUNT_HI;
            COUNT_LO: if (xfer) state_d = {16'd0, n} > 32'(MEM_WORDS) ? ERROR : n == 16'd0 ? AFTER_DATA : DATA;
            DATA:     if (word_end && idx_q + 16'd1 == count_q) state_d = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            CHECK:    if (xfer) state_d = bus.byte_data == csum_q ? FLUSH : ERROR;
`endif
            FLUSH:    state_d = flush_q ? RUN : FLUSH;
            RUN:      state_d = load ? COUNT_HI : RUN;
            ERROR:    state_d = load ? COUNT_HI : ERROR;
            default:  state_d = COUNT_HI;
        endcase
    end
    always_comb begin
        count_d = count_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        val_d   = val_q;
        we_d    = word_end;
        flush_d = state_q == FLUSH && !flush_q;
        words_d = words_q + {15'd0, we_q};
        if (xfer && state_q == COUNT_HI) count_d = {bus.byte_data, 8'h00};
        if (xfer && state_q == COUNT_LO) count_d = n;
        if (xfer && state_q == DATA) begin
            word_d = {word_q[15:0], bus.byte_data};
            bcnt_d = bcnt_q + 2'd1;
        end
        if (word_end) begin
            addr_d = {14'd0, idx_q, 2'b00};
            val_d  = {word_q, bus.byte_data};
            idx_d  = idx_q + 16'd1;
        end
        if (load) begin
            idx_d   = '0;
            bcnt_d  = '0;
            words_d = '0;
        end
    end
`ifdef LOADER_CHECKSUM_EN
    always_comb csum_d = load ? 8'h00 : xfer && state_q == DATA ? csum_q ^ bus.byte_data : csum_q;
    always_ff @(posedge clock_i) csum_q <= reset_i ? 8'h00 : csum_d;
`endif
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            val_q   <= '0;
            we_q    <= 1'b0;
            flush_q <= 1'b0;
            words_q <= '0;
        end else begin
            count_q <= count_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            val_q   <= val_d;
            we_q    <= we_d;
            flush_q <= flush_d;
            words_q <= words_d;
        end
    end
    always_comb begin
        bus.byte_ready         = !(state_q inside {FLUSH, RUN, ERROR});
        bus.processor_reset    = state_q != RUN;
        bus.loader_done        = state_q == RUN;
        bus.loader_error       = state_q == ERROR;
        bus.imem_write_enable  = we_q;
        bus.imem_write_address = addr_q;
        bus.imem_write_value   = val_q;
        bus.words_loaded       = words_q;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized streams for program_loader, checked against a stream-level model.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  strm[$];
    logic [31:0] exp_w[$];
    logic [31:0] got_a[$];
    logic [31:0] got_v[$];
    int          got_c[$];
    int          acc_cyc[$];
    program_loader_if bus();
    program_loader #(.MEM_WORDS(256)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.imem_write_enable === 1'b1) begin
        got_a.push_back(bus.imem_write_address);
        got_v.push_back(bus.imem_write_value);
        got_c.push_back(cyc);
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // Reference stream: count, then words MSB first, then the XOR of all data bytes if enabled.
    task automatic build(input int n);
        logic [7:0] cs;
        logic [7:0] x;
        cs = 8'h00;
        strm.delete();
        strm.push_back(8'(n >> 8));
        strm.push_back(8'(n));
        foreach (exp_w[i]) for (int b = 3; b >= 0; b--) begin
            x = 8'(exp_w[i] >> (8 * b));
            strm.push_back(x);
            cs = cs ^ x;
        end
`ifdef LOADER_CHECKSUM_EN
        strm.push_back(cs);
`endif
    endtask
    task automatic send(input int gap);
        logic ok;
        acc_cyc.delete();
        foreach (strm[i]) begin
            bus.byte_valid = 1'b0;
            repeat (gap) step();
            bus.byte_valid = 1'b1;
            bus.byte_data = strm[i];
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                ok = bus.byte_ready;
                if (ok) acc_cyc.push_back(cyc);
                step();
            end
            chk1("byte_accepted", ok, 1'b1);
        end
        bus.byte_valid = 1'b0;
    endtask
    task automatic expect_release();
        @(negedge clk);
        chk1("flush_ready", bus.byte_ready, 1'b0);
        chk1("flush_prst1", bus.processor_reset, 1'b1);
        @(negedge clk);
        chk1("flush_prst2", bus.processor_reset, 1'b1);
        chk1("flush_done", bus.loader_done, 1'b0);
        @(negedge clk);
        chk1("run_prst", bus.processor_reset, 1'b0);
        chk1("run_done", bus.loader_done, 1'b1);
        step();
    endtask
    task automatic check_writes();
        chk("n_writes", got_a.size(), exp_w.size());
        foreach (exp_w[i]) if (i < got_a.size()) begin
            chk("wr_addr", got_a[i], 32'(i * 4));
            chk("wr_val", got_v[i], exp_w[i]);
            chk("wr_cycle", got_c[i], acc_cyc[5 + 4 * i] + 1);
        end
        chk("words_loaded", 32'(bus.words_loaded), exp_w.size());
        got_a.delete();
        got_v.delete();
        got_c.delete();
    endtask
    task automatic reload();
        bus.load_request = 1'b1;
        step();
        bus.load_request = 1'b0;
        @(negedge clk);
        chk1("reload_prst", bus.processor_reset, 1'b1);
        chk1("reload_ready", bus.byte_ready, 1'b1);
        chk1("reload_err", bus.loader_error, 1'b0);
        chk("reload_words", 32'(bus.words_loaded), 0);
        step();
    endtask
    task automatic full_load(input int gap);
        build(exp_w.size());
        send(gap);
        expect_release();
        check_writes();
    endtask
    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data = 8'h00;
        bus.load_request = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_prst", bus.processor_reset, 1'b1);
        chk1("rst_ready", bus.byte_ready, 1'b1);
        chk1("rst_we", bus.imem_write_enable, 1'b0);
        chk("rst_addr", bus.imem_write_address, 0);
        chk("rst_val", bus.imem_write_value, 0);
        chk1("rst_done", bus.loader_done, 1'b0);
        chk1("rst_err", bus.loader_error, 1'b0);
        chk("rst_words", 32'(bus.words_loaded), 0);
        step();
        exp_w = '{32'h12345678, 32'h9ABCDEF0};
        full_load(0);
        reload();
        full_load(3);
        reload();
        exp_w.delete();
        strm = '{8'h01, 8'h01};
        send(0);
        @(negedge clk);
        chk1("ovf_err", bus.loader_error, 1'b1);
        chk1("ovf_ready", bus.byte_ready, 1'b0);
        chk1("ovf_prst", bus.processor_reset, 1'b1);
        check_writes();
        step();
        reload();
        exp_w.delete();
        full_load(1);
`ifdef LOADER_CHECKSUM_EN
        reload();
        exp_w = '{32'h00000001};
        strm = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        send(0);
        @(negedge clk);
        chk1("csum_err", bus.loader_error, 1'b1);
        chk1("csum_prst", bus.processor_reset, 1'b1);
        check_writes();
        step();
        reload();
        exp_w = '{32'h12345678, 32'h9ABCDEF0};
        full_load(0);
`endif
        reload();
        strm = '{8'h00, 8'h02, 8'h12, 8'h34};
        send(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("midrst_ready", bus.byte_ready, 1'b1);
        chk1("midrst_prst", bus.processor_reset, 1'b1);
        chk("midrst_words", 32'(bus.words_loaded), 0);
        chk("midrst_nwr", got_a.size(), 0);
        step();
        exp_w = '{32'h12345678, 32'h9ABCDEF0};
        full_load(0);
        reload();
        strm = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("strbrst_we", bus.imem_write_enable, 1'b0);
        chk("strbrst_words", 32'(bus.words_loaded), 0);
        chk("strbrst_addr", bus.imem_write_address, 0);
        chk("strbrst_nwr", got_a.size(), 1);
        got_a.delete();
        got_v.delete();
        got_c.delete();
        step();
        for (int r = 0; r < 4; r++) begin
            exp_w.delete();
            repeat ($urandom_range(1, 6)) exp_w.push_back($urandom());
            full_load(int'($urandom_range(0, 2)));
            reload();
        end
        exp_w.delete();
        repeat (256) exp_w.push_back($urandom());
        full_load(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
